// File: rtl/intr_priority_if.sv
// intr_priority_if: request, handshake and status signals between the interrupt controller and its CPU/peripheral side
interface intr_priority_if #(
    parameter int N_CH   = 4,
    parameter int MODE_W = 3,
    parameter int ID_W   = 2
);
    logic [N_CH-1:0]        irq_in;
    logic [N_CH-1:0]        mask;
    logic [N_CH*MODE_W-1:0] mode_flat;
    logic                   en_intr;
    logic                   int_ack;
    logic                   int_eoi;
    logic                   irq_out;
    logic [ID_W-1:0]        out_id;
    logic [MODE_W-1:0]      out_mode;
    logic                   busy;
    logic [N_CH-1:0]        pending;

    modport master (
        output irq_in, mask, mode_flat, en_intr, int_ack, int_eoi,
        input  irq_out, out_id, out_mode, busy, pending
    );

    modport slave (
        input  irq_in, mask, mode_flat, en_intr, int_ack, int_eoi,
        output irq_out, out_id, out_mode, busy, pending
    );
endinterface

// File: rtl/intr_priority_ctrl.sv
// intr_priority_ctrl: edge-triggered interrupt controller with masking, ack/EOI handshake; `define INTR_ROUND_ROBIN_EN for rotating priority
module intr_priority_ctrl #(
    parameter int N_CH   = 4,
    parameter int MODE_W = 3,
    parameter int ID_W   = 2
) (
    input logic             clk,
    input logic             rst_n,
    intr_priority_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t            state, state_nx;
    logic [N_CH-1:0]   irq_q, irq_qq, edge_vec, req_vec, clr, pending_r;
    logic [1:0]        arm;
    logic [ID_W-1:0]   winner, out_id_r;
    logic [MODE_W-1:0] out_mode_r;
    logic              take;
`ifdef INTR_ROUND_ROBIN_EN
    logic [ID_W-1:0]   rr_ptr;
    logic              found;
    int                idx;
`endif

    // arm gates edges until both sync stages hold real samples, so lines high across reset raise nothing
    assign edge_vec = irq_q & ~irq_qq & {N_CH{arm[1]}};
    assign req_vec  = pending_r & ~bus.mask;
    assign take     = (state == REQ) && bus.en_intr && (|req_vec) && bus.int_ack;
    assign clr      = take ? (N_CH'(1) << winner) : '0;

    assign bus.irq_out  = (state == REQ);
    assign bus.busy     = (state == SERVICE);
    assign bus.out_id   = out_id_r;
    assign bus.out_mode = out_mode_r;
    assign bus.pending  = pending_r;

    // winner selection: fixed (index 0 highest) or rotating from rr_ptr
    always_comb begin
        winner = '0;
`ifdef INTR_ROUND_ROBIN_EN
        found = 1'b0;
        idx   = 0;
        for (int j = 0; j < N_CH; j++) begin
            idx = (int'(rr_ptr) + j) % N_CH;
            if (!found && req_vec[idx]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
`else
        for (int i = N_CH - 1; i >= 0; i--)
            if (req_vec[i]) winner = ID_W'(i);
`endif
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (bus.en_intr && |req_vec) ? REQ : IDLE;
            REQ:     state_nx = (!bus.en_intr || !(|req_vec)) ? IDLE : (bus.int_ack ? SERVICE : REQ);
            SERVICE: state_nx = bus.int_eoi ? IDLE : SERVICE;
            default: state_nx = IDLE;
        endcase
    end

    // state, edge-detect, pending and captured-winner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            irq_q      <= '0;
            irq_qq     <= '0;
            arm        <= '0;
            pending_r  <= '0;
            out_id_r   <= '0;
            out_mode_r <= '0;
        end else begin
            state     <= state_nx;
            irq_q     <= bus.irq_in;
            irq_qq    <= irq_q;
            arm       <= {arm[0], 1'b1};
            pending_r <= (pending_r & ~clr) | edge_vec;
            if (take) begin
                out_id_r   <= winner;
                out_mode_r <= bus.mode_flat[int'(winner)*MODE_W +: MODE_W];
            end
        end
    end

`ifdef INTR_ROUND_ROBIN_EN
    // rotate priority past each accepted winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (take)
            rr_ptr <= (winner == ID_W'(N_CH - 1)) ? '0 : winner + 1'b1;
    end
`endif
endmodule
